// File: rtl/fetch_pkg.sv
// Purpose: shared fetch/decode constants and small width helpers.
// Latency: n/a (package only).
// Backpressure: n/a.
package fetch_pkg;

    localparam int          FETCH_ADDR_W   = 32;
    localparam int          FETCH_DATA_W   = 32;
    localparam int          FETCH_PC_STEP  = 4;
    localparam logic [31:0] FETCH_RESET_PC = 32'h0000_0000;

    // Width of a counter that must hold 0..n inclusive (never narrower than 1 bit).
    function automatic int fetch_cnt_w(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

    // Width of an index into n entries (never narrower than 1 bit).
    function automatic int fetch_ptr_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Purpose: DEPTH-entry synchronous FIFO with flush and occupancy count.
// Latency: a push is visible at the head the cycle after it is written (no bypass).
// Backpressure: none internally; pushes into a full FIFO without a pop are dropped.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter  int DEPTH = 4,
    parameter  int W     = 64,
    localparam int PTR_W = fetch_ptr_w(DEPTH),
    localparam int CNT_W = fetch_cnt_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [W-1:0]     push_dat_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output logic [W-1:0]     head_dat_o,
    output logic [CNT_W-1:0] count_o
);

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    // Pointers wrap at DEPTH, which need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign do_pop  = pop_i & (count_q != '0);
    assign do_push = push_i & ((count_q != CNT_W'(DEPTH)) | do_pop);

    // Next pointers and count; flush empties the FIFO regardless of push/pop.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and count registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are only meaningful below count, so no reset.
    always_ff @(posedge clk) begin
        if (do_push && !flush_i) begin
            mem_q[wr_ptr_q] <= push_dat_i;
        end
    end

    assign head_dat_o = mem_q[rd_ptr_q];
    assign count_o    = count_q;

endmodule

// File: rtl/fetch_queue.sv
// Purpose: sequential instruction fetch into a fixed-latency memory, buffered for decode; FETCH_PERF_EN adds perf counters.
// Latency: request in cycle t -> instr_valid in cycle t+MEM_LAT+1.
// Backpressure: credit = DEPTH - (queued + in-flight); issue stalls at zero credit, halt or redirect.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = FETCH_ADDR_W,
    parameter int                DATA_W   = FETCH_DATA_W,
    parameter int                MEM_LAT  = 2,
    parameter int                DEPTH    = 4,
    parameter int                PC_STEP  = FETCH_PC_STEP,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(FETCH_RESET_PC)
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              halt,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic [31:0]       perf_issued,
    output logic [31:0]       perf_killed
);

    localparam int IF_W  = fetch_cnt_w(MEM_LAT);
    localparam int CNT_W = fetch_cnt_w(DEPTH);
    localparam int ENT_W = DATA_W + ADDR_W;

    logic [ADDR_W-1:0]              pc_q, pc_d;
    logic [MEM_LAT-1:0]             pipe_vld_q, pipe_vld_d;
    logic [MEM_LAT-1:0][ADDR_W-1:0] pipe_pc_q, pipe_pc_d;
    logic [IF_W-1:0]                inflight_q, inflight_d;
    logic [CNT_W-1:0]               fifo_cnt;
    logic [ENT_W-1:0]               fifo_head;
    logic                           credit_ok;
    logic                           issue;
    logic                           ret_vld;
    logic                           push;
    logic                           pop;

    // Credit uses registered counts only, so a pop frees its slot a cycle later.
    assign credit_ok = (int'(fifo_cnt) + int'(inflight_q)) < DEPTH;
    assign issue     = rst_n & ~halt & ~redirect & credit_ok;
    assign mem_req   = issue;
    assign mem_addr  = pc_q;

    // The oldest pipe slot lines up with mem_rdata; a redirect kills it.
    assign ret_vld     = pipe_vld_q[MEM_LAT-1];
    assign push        = ret_vld & ~redirect;
    assign instr_valid = rst_n & (fifo_cnt != '0);
    assign pop         = instr_valid & instr_ready;
    assign instr       = fifo_head[ADDR_W +: DATA_W];
    assign instr_pc    = fifo_head[ADDR_W-1:0];

    // Next pc: redirect wins, otherwise advance (silently wrapping) on issue.
    always_comb begin
        pc_d = pc_q;
        if (redirect) begin
            pc_d = redirect_pc;
        end else if (issue) begin
            pc_d = pc_q + ADDR_W'(PC_STEP);
        end
    end

    // In-flight shift pipe: slot 0 takes the new request, redirect clears every valid bit.
    always_comb begin
        pipe_vld_d    = '0;
        pipe_pc_d     = '0;
        pipe_vld_d[0] = issue;
        pipe_pc_d[0]  = pc_q;
        for (int i = 1; i < MEM_LAT; i++) begin
            pipe_vld_d[i] = pipe_vld_q[i-1];
            pipe_pc_d[i]  = pipe_pc_q[i-1];
        end
        if (redirect) begin
            pipe_vld_d = '0;
        end
    end

    // In-flight count tracks issues minus returns; redirect forgets everything outstanding.
    always_comb begin
        inflight_d = inflight_q;
        if (redirect) begin
            inflight_d = '0;
        end else begin
            case ({issue, ret_vld})
                2'b10:   inflight_d = inflight_q + IF_W'(1);
                2'b01:   inflight_d = inflight_q - IF_W'(1);
                default: inflight_d = inflight_q;
            endcase
        end
    end

    // Control state registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q       <= RESET_PC;
            pipe_vld_q <= '0;
            inflight_q <= '0;
        end else begin
            pc_q       <= pc_d;
            pipe_vld_q <= pipe_vld_d;
            inflight_q <= inflight_d;
        end
    end

    // Pipe addresses are qualified by the valid bits and need no reset.
    always_ff @(posedge clk) begin
        pipe_pc_q <= pipe_pc_d;
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .W     (ENT_W)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_i     (push),
        .push_dat_i ({mem_rdata, pipe_pc_q[MEM_LAT-1]}),
        .pop_i      (pop),
        .flush_i    (redirect),
        .head_dat_o (fifo_head),
        .count_o    (fifo_cnt)
    );

`ifdef FETCH_PERF_EN
    logic [31:0] perf_issued_q, perf_issued_d;
    logic [31:0] perf_killed_q, perf_killed_d;

    function automatic logic [31:0] popcnt(input logic [MEM_LAT-1:0] v);
        logic [31:0] n;
        n = '0;
        for (int i = 0; i < MEM_LAT; i++) begin
            n = n + {31'd0, v[i]};
        end
        return n;
    endfunction

    // Count issued requests and the valid slots thrown away at each redirect.
    always_comb begin
        perf_issued_d = perf_issued_q + {31'd0, issue};
        perf_killed_d = perf_killed_q;
        if (redirect) begin
            perf_killed_d = perf_killed_q + popcnt(pipe_vld_q);
        end
    end

    // Perf counter registers, wrapping at 2^32.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_issued_q <= '0;
            perf_killed_q <= '0;
        end else begin
            perf_issued_q <= perf_issued_d;
            perf_killed_q <= perf_killed_d;
        end
    end

    assign perf_issued = perf_issued_q;
    assign perf_killed = perf_killed_q;
`else
    assign perf_issued = '0;
    assign perf_killed = '0;
`endif

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Parametrised successor to the two-stage fetch_a/fetch_b front end of pipelined_cpu.
- Issues sequential instruction reads to a fixed-latency memory port of configurable depth (MEM_LAT).
- Tracks in-flight requests and buffers returned instructions in a DEPTH-entry queue.
- Presents instructions to decode over a valid/ready handshake. Supports redirect (branch/flush) and halt.

Parameters:
- ADDR_W, 32, address and PC width.
- DATA_W, 32, instruction width.
- MEM_LAT, 2, cycles from request to read data; must be >= 1.
- DEPTH, 4, instruction queue entries; must be >= 1. Full throughput requires DEPTH >= MEM_LAT+2.
- PC_STEP, 4, byte increment per instruction.
- RESET_PC, 0, first fetch address after reset.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst_n  in  1  synchronous active-low reset.
- mem_req  out  1  read request this cycle.
- mem_addr  out  ADDR_W  read address; valid when mem_req=1.
- mem_rdata  in  DATA_W  read data, valid exactly MEM_LAT cycles after its request.
- redirect  in  1  flush and refetch from redirect_pc.
- redirect_pc  in  ADDR_W  new fetch address.
- halt  in  1  stop issuing new requests; level-sensitive.
- instr_valid  out  1  queue head valid.
- instr_ready  in  1  decode accepts head.
- instr  out  DATA_W  head instruction.
- instr_pc  out  ADDR_W  address of head instruction.
- perf_issued  out  32  requests issued (FETCH_PERF_EN).
- perf_killed  out  32  responses discarded by redirect (FETCH_PERF_EN).

Behaviour:
- Reset (rst_n=0 at an edge):
  - pc <= RESET_PC.
  - In-flight pipe cleared, queue emptied, perf counters cleared.
  - While rst_n=0, mem_req=0 and instr_valid=0.
  - instr, instr_pc and mem_addr are don't-care.
- Reset mid-operation discards all in-flight and queued data; no late response is ever enqueued.
- State:
  - pc register.
  - In-flight shift pipe of MEM_LAT slots {valid, pc}.
  - Queue of DEPTH entries {instr, pc}.
  - Occupancy count (0..DEPTH).
  - In-flight count (0..MEM_LAT).
- Issue:
  - mem_req = rst_n & ~halt & ~redirect & (count + inflight_cnt < DEPTH), using registered counts.
  - A pop in the same cycle does not free credit until the next cycle.
  - mem_addr = pc.
  - On issue, pc <= pc + PC_STEP, mod 2^ADDR_W, so wrap-around is silent.
  - Slot 0 of the pipe gets {1, pc}.
- Return:
  - Pipe slot MEM_LAT-1 valid at an edge pushes {mem_rdata, slot pc} into the queue.
  - The credit rule guarantees this push never overflows.
- Output and pop:
  - instr_valid = count != 0.
  - instr/instr_pc show the head entry.
  - A pop happens when instr_valid & instr_ready.
  - Push and pop in the same cycle leave count unchanged.
  - A push into an empty queue becomes visible the following cycle; there is no bypass.
- Latency: request issued in cycle t, data enqueued at the end of cycle t+MEM_LAT, instr_valid in cycle t+MEM_LAT+1.
- Redirect:
  - At the edge: pc <= redirect_pc, all pipe valid bits cleared, queue emptied.
  - No request is issued in the redirect cycle; the first request to redirect_pc goes out the next cycle.
  - Redirect wins over a simultaneous push, pop or issue.
  - Data already returning in that cycle is discarded.
- Halt:
  - Suppresses issue only.
  - In-flight requests still return and the queue still drains.
  - Deasserting halt resumes issue at the held pc.
- halt and redirect together: state is redirected; issue resumes once halt falls.

Optional Feature:
- Macro FETCH_PERF_EN.
- When defined:
  - perf_issued increments on every mem_req.
  - perf_killed increments, at a redirect edge, by the number of valid pipe slots discarded.
  - Both counters wrap at 2^32 and clear on reset.
- When undefined: both ports are driven constant 0 and no counter flops exist.

Decomposition:
- Package fetch_pkg holds the shared constants: default PC_STEP, RESET_PC and the ADDR_W/DATA_W defaults, also used by decode.
- One natural sub-module, fetch_fifo: synchronous DEPTH-entry FIFO with push, pop, flush and count output, handling wrap of its read/write pointers.
- Issue logic and the in-flight pipe stay in fetch_queue.

Test Plan:
- Reset, then stream (MEM_LAT=2, DEPTH=4, instr_ready=1, memory returns addr^32'hA5A5_0000):
  - mem_req=1 with addr 0 in the first cycle after rst_n rises.
  - instr_valid rises 3 cycles later with instr_pc=0.
  - One instruction per cycle after that, pc 0,4,8,...
- Backpressure, instr_ready=0 held:
  - Exactly 4 requests issued, then mem_req=0.
  - Count reaches 4, no overflow.
  - Raising ready drains 0,4,8,12 in order and issue resumes.
- Redirect to 0x100 with 2 requests in flight and 2 queued:
  - Next cycle instr_valid=0 and mem_req=1 with addr 0x100.
  - No stale pc ever appears at the output.
  - perf_killed += 2 with FETCH_PERF_EN.
- Halt asserted mid-stream:
  - mem_req drops the same cycle.
  - In-flight responses still appear at the output.
  - Releasing halt resumes at the next sequential pc.
- Wrap: RESET_PC=32'hFFFF_FFF8 produces fetches FFFF_FFF8, FFFF_FFFC, 0000_0000.
- rst_n low for one cycle while the queue is full: instr_valid=0 next cycle and refetch restarts from RESET_PC.
